// File: rtl/fiber_bank_if.sv
// rtl/fiber_bank_if.sv - PE request/response and DRAM fill/writeback signal bundle for fiber_bank
interface fiber_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64
);
  logic [3:0]            i_request_type;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_type_valid;
  logic                  o_type_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_pe_data_o;
  logic                  o_pe_data_o_valid;
  logic                  i_pe_data_o_ready;
  logic [ADDR_WIDTH-1:0] o_dram_addr;
  logic [DATA_WIDTH-1:0] i_dram_data;
  logic                  i_dram_data_i_valid;
  logic                  o_dram_data_i_ready;
  logic [DATA_WIDTH-1:0] o_dram_data_o;
  logic                  o_dram_data_o_valid;
  logic                  i_dram_data_o_ready;

  modport master (
    output i_request_type, i_addr, i_type_valid, i_data, i_pe_data_o_ready,
           i_dram_data, i_dram_data_i_valid, i_dram_data_o_ready,
    input  o_type_ready, o_pe_data_o, o_pe_data_o_valid, o_dram_addr,
           o_dram_data_i_ready, o_dram_data_o, o_dram_data_o_valid
  );

  modport slave (
    input  i_request_type, i_addr, i_type_valid, i_data, i_pe_data_o_ready,
           i_dram_data, i_dram_data_i_valid, i_dram_data_o_ready,
    output o_type_ready, o_pe_data_o, o_pe_data_o_valid, o_dram_addr,
           o_dram_data_i_ready, o_dram_data_o, o_dram_data_o_valid
  );
endinterface

// File: rtl/fiber_bank.sv
// rtl/fiber_bank.sv - one FiberCache bank: set-associative write-back cache with priority/SRRIP replacement
module fiber_bank #(
  parameter int DATA_WIDTH    = 16,
  parameter int SETS          = 256,
  parameter int WAYS          = 16,
  parameter int ADDR_WIDTH    = 64,
  parameter int SRRIP_BITS    = 2,
  parameter int PRIORITY_BITS = 5
) (
  input logic        i_clk,
  input logic        i_nreset,
  fiber_bank_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [3:0] T_FETCH   = 4'b0001;
  localparam logic [3:0] T_READ    = 4'b0010;
  localparam logic [3:0] T_WRITE   = 4'b0100;
  localparam logic [3:0] T_CONSUME = 4'b1000;

  localparam logic [SRRIP_BITS-1:0]    RRPV_MAX = '1;
  localparam logic [SRRIP_BITS-1:0]    RRPV_ONE = SRRIP_BITS'(1);
  localparam logic [SRRIP_BITS-1:0]    RRPV_INS = RRPV_MAX - RRPV_ONE;
  localparam logic [PRIORITY_BITS-1:0] PRIO_MAX = '1;
  localparam logic [PRIORITY_BITS-1:0] PRIO_ONE = PRIORITY_BITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_RESP} state_t;
  state_t state_q, state_d;

  // Per-line state; valid/dirty/rrpv/priority are reset, tag/data are not.
  logic                     valid_q [SETS][WAYS];
  logic                     dirty_q [SETS][WAYS];
  logic [SRRIP_BITS-1:0]    rrpv_q  [SETS][WAYS];
  logic [PRIORITY_BITS-1:0] prio_q  [SETS][WAYS];
  logic [TAG_W-1:0]         tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]    data_q  [SETS][WAYS];

  logic [3:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [WAY_W-1:0]      way_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req_ok;
  assign idx    = addr_q[IDX_W-1:0];
  assign tag    = addr_q[ADDR_WIDTH-1:IDX_W];
  assign req_ok = (type_q == T_FETCH) || (type_q == T_READ) ||
                  (type_q == T_WRITE) || (type_q == T_CONSUME);

  logic             hit, free_found, vict_dirty;
  logic [WAY_W-1:0] hit_way, free_way, min_way, vict_way;

  // Tag match and victim choice: first invalid way, else min priority, max RRPV, lowest index.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    min_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!free_found && !valid_q[idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    for (int w = 1; w < WAYS; w++) begin
      if ((prio_q[idx][w] < prio_q[idx][min_way]) ||
          ((prio_q[idx][w] == prio_q[idx][min_way]) && (rrpv_q[idx][w] > rrpv_q[idx][min_way])))
        min_way = WAY_W'(w);
    end
    vict_way   = free_found ? free_way : min_way;
    vict_dirty = valid_q[idx][vict_way] && dirty_q[idx][vict_way];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.i_type_valid) state_d = S_LOOKUP;
      S_LOOKUP: begin
        state_d = S_IDLE;
        if (req_ok) begin
          if (hit) begin
            if ((type_q == T_READ) || (type_q == T_CONSUME)) state_d = S_RESP;
          end else if (type_q == T_CONSUME) begin
            state_d = S_FILL;
          end else if (vict_dirty) begin
            state_d = S_EVICT;
          end else if (type_q != T_WRITE) begin
            state_d = S_FILL;
          end
        end
      end
      S_EVICT:  if (bus.i_dram_data_o_ready) state_d = (type_q == T_WRITE) ? S_IDLE : S_FILL;
      S_FILL:   if (bus.i_dram_data_i_valid) state_d = (type_q == T_FETCH) ? S_IDLE : S_RESP;
      S_RESP:   if (bus.i_pe_data_o_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  logic                     inst_en, inst_dirty;
  logic [WAY_W-1:0]         inst_way;
  logic [DATA_WIDTH-1:0]    inst_data;
  logic [PRIORITY_BITS-1:0] inst_prio;

  // Line installation: clean-victim WRITE, WRITE after writeback, or DRAM fill (CONSUME never allocates).
  always_comb begin
    inst_en    = 1'b0;
    inst_dirty = 1'b0;
    inst_way   = way_q;
    inst_data  = bus.i_dram_data;
    inst_prio  = '0;
    case (state_q)
      S_LOOKUP: if (!hit && (type_q == T_WRITE) && !vict_dirty) begin
        inst_en    = 1'b1;
        inst_way   = vict_way;
        inst_data  = wdata_q;
        inst_dirty = 1'b1;
      end
      S_EVICT: if (bus.i_dram_data_o_ready && (type_q == T_WRITE)) begin
        inst_en    = 1'b1;
        inst_data  = wdata_q;
        inst_dirty = 1'b1;
      end
      S_FILL: if (bus.i_dram_data_i_valid && ((type_q == T_FETCH) || (type_q == T_READ))) begin
        inst_en   = 1'b1;
        inst_prio = (type_q == T_FETCH) ? PRIO_ONE : '0;
      end
      default: ;
    endcase
  end

  // FSM state, request latch, response capture and replacement metadata.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      way_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          rrpv_q[s][w]  <= '0;
          prio_q[s][w]  <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && bus.i_type_valid) begin
        type_q  <= bus.i_request_type;
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_data;
      end
      if (state_q == S_LOOKUP) begin
        if (hit && req_ok) begin
          case (type_q)
            T_FETCH: begin
              rrpv_q[idx][hit_way] <= '0;
              if (prio_q[idx][hit_way] != PRIO_MAX)
                prio_q[idx][hit_way] <= prio_q[idx][hit_way] + PRIO_ONE;
            end
            T_READ: begin
              rrpv_q[idx][hit_way] <= '0;
              resp_q <= data_q[idx][hit_way];
            end
            T_WRITE: begin
              rrpv_q[idx][hit_way]  <= '0;
              dirty_q[idx][hit_way] <= 1'b1;
            end
            default: begin
              resp_q <= data_q[idx][hit_way];
              if (prio_q[idx][hit_way] <= PRIO_ONE) begin
                prio_q[idx][hit_way]  <= '0;
                valid_q[idx][hit_way] <= 1'b0;
                dirty_q[idx][hit_way] <= 1'b0;
              end else begin
                prio_q[idx][hit_way] <= prio_q[idx][hit_way] - PRIO_ONE;
              end
            end
          endcase
        end else if (!hit) begin
          way_q <= vict_way;
        end
      end
      if ((state_q == S_EVICT) && bus.i_dram_data_o_ready) dirty_q[idx][way_q] <= 1'b0;
      if ((state_q == S_FILL) && bus.i_dram_data_i_valid) resp_q <= bus.i_dram_data;
      if (inst_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if ((WAY_W'(w) != inst_way) && valid_q[idx][w] && (rrpv_q[idx][w] != RRPV_MAX))
            rrpv_q[idx][w] <= rrpv_q[idx][w] + RRPV_ONE;
        end
        valid_q[idx][inst_way] <= 1'b1;
        dirty_q[idx][inst_way] <= inst_dirty;
        rrpv_q[idx][inst_way]  <= RRPV_INS;
        prio_q[idx][inst_way]  <= inst_prio;
      end
    end
  end

  // Tag and data storage writes (no reset: contents are qualified by valid).
  always_ff @(posedge i_clk) begin
    if (inst_en) begin
      tag_q[idx][inst_way]  <= tag;
      data_q[idx][inst_way] <= inst_data;
    end else if ((state_q == S_LOOKUP) && hit && (type_q == T_WRITE)) begin
      data_q[idx][hit_way] <= wdata_q;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.o_type_ready        = (state_q == S_IDLE);
    bus.o_pe_data_o_valid   = (state_q == S_RESP);
    bus.o_pe_data_o         = (state_q == S_RESP) ? resp_q : '0;
    bus.o_dram_data_i_ready = (state_q == S_FILL);
    bus.o_dram_data_o_valid = (state_q == S_EVICT);
    bus.o_dram_data_o       = '0;
    bus.o_dram_addr         = '0;
    if (state_q == S_EVICT) begin
      bus.o_dram_addr   = {tag_q[idx][way_q], idx};
      bus.o_dram_data_o = data_q[idx][way_q];
    end else if (state_q == S_FILL) begin
      bus.o_dram_addr = addr_q;
    end
  end
endmodule

// File: tb/tb_fiber_bank.sv
// tb/tb_fiber_bank.sv - directed self-checking bench for fiber_bank
module tb_fiber_bank;
  localparam logic [3:0] FETCH   = 4'b0001;
  localparam logic [3:0] READ    = 4'b0010;
  localparam logic [3:0] WRITE   = 4'b0100;
  localparam logic [3:0] CONSUME = 4'b1000;

  logic i_clk = 1'b0;
  logic i_nreset = 1'b0;
  int checks = 0;
  int failures = 0;

  fiber_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(64)) bus ();

  fiber_bank #(
    .DATA_WIDTH(16), .SETS(256), .WAYS(16), .ADDR_WIDTH(64), .SRRIP_BITS(2), .PRIORITY_BITS(5)
  ) dut (
    .i_clk    (i_clk),
    .i_nreset (i_nreset),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running expected=done");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [3:0] t, input logic [63:0] a, input logic [15:0] d);
    bus.i_request_type = t;
    bus.i_addr         = a;
    bus.i_data         = d;
    bus.i_type_valid   = 1'b1;
    step();
    bus.i_type_valid   = 1'b0;
  endtask

  task automatic fill(input logic [15:0] d);
    bus.i_dram_data         = d;
    bus.i_dram_data_i_valid = 1'b1;
    step();
    bus.i_dram_data_i_valid = 1'b0;
  endtask

  task automatic pe_take();
    bus.i_pe_data_o_ready = 1'b1;
    step();
    bus.i_pe_data_o_ready = 1'b0;
  endtask

  task automatic test_reset();
    #25;
    checks++; if (bus.o_type_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready actual=%b expected=1", bus.o_type_ready); end
    @(negedge i_clk);
    i_nreset = 1'b1;
    @(negedge i_clk);
    checks++; if (bus.o_type_ready !== 1'b1) begin failures++; $display("FAIL rst_type_ready actual=%b expected=1", bus.o_type_ready); end
    checks++; if ({bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid} !== 3'b000) begin
      failures++; $display("FAIL rst_valids actual=%b expected=000", {bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid}); end
    checks++; if ({bus.o_pe_data_o, bus.o_dram_data_o, bus.o_dram_addr} !== 96'h0) begin
      failures++; $display("FAIL rst_data actual=%h expected=0", {bus.o_pe_data_o, bus.o_dram_data_o, bus.o_dram_addr}); end
  endtask

  task automatic test_fetch_miss();
    issue(FETCH, 64'h0000_0000_FFFF_FFFF, 16'h0);
    checks++; if (bus.o_type_ready !== 1'b0) begin failures++; $display("FAIL fetch_busy actual=%b expected=0", bus.o_type_ready); end
    step();
    checks++; if (bus.o_dram_data_i_ready !== 1'b1) begin failures++; $display("FAIL fetch_fill_rdy actual=%b expected=1", bus.o_dram_data_i_ready); end
    checks++; if (bus.o_dram_addr !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL fetch_addr actual=%h expected=00000000ffffffff", bus.o_dram_addr); end
    fill(16'h0000);
    checks++; if ({bus.o_type_ready, bus.o_dram_data_i_ready, bus.o_pe_data_o_valid} !== 3'b100) begin
      failures++; $display("FAIL fetch_done actual=%b expected=100", {bus.o_type_ready, bus.o_dram_data_i_ready, bus.o_pe_data_o_valid}); end
  endtask

  task automatic test_read_hold();
    bus.i_request_type = READ;
    bus.i_addr         = 64'h0000_0000_FFFF_FFFF;
    bus.i_type_valid   = 1'b1;
    step();
    checks++; if (bus.o_type_ready !== 1'b0) begin failures++; $display("FAIL rd_busy actual=%b expected=0", bus.o_type_ready); end
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o} !== 17'h1_0000) begin
      failures++; $display("FAIL rd_resp actual=%h expected=10000", {bus.o_pe_data_o_valid, bus.o_pe_data_o}); end
    checks++; if ({bus.o_dram_data_i_ready, bus.o_dram_data_o_valid} !== 2'b00) begin
      failures++; $display("FAIL rd_no_dram actual=%b expected=00", {bus.o_dram_data_i_ready, bus.o_dram_data_o_valid}); end
    step();
    bus.i_type_valid = 1'b0;
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_type_ready} !== 18'h2_0000) begin
      failures++; $display("FAIL rd_hold actual=%h expected=20000", {bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_type_ready}); end
    pe_take();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_type_ready} !== 2'b01) begin
      failures++; $display("FAIL rd_release actual=%b expected=01", {bus.o_pe_data_o_valid, bus.o_type_ready}); end
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_type_ready} !== 2'b01) begin
      failures++; $display("FAIL rd_once actual=%b expected=01", {bus.o_pe_data_o_valid, bus.o_type_ready}); end
  endtask

  task automatic test_write_evict();
    for (int k = 1; k <= 16; k++) begin
      issue(WRITE, 64'(k) << 8, 16'hABCD);
      step();
      checks++; if ({bus.o_type_ready, bus.o_dram_data_o_valid, bus.o_dram_data_i_ready} !== 3'b100) begin
        failures++; $display("FAIL wr_install_%0d actual=%b expected=100", k, {bus.o_type_ready, bus.o_dram_data_o_valid, bus.o_dram_data_i_ready}); end
    end
    issue(WRITE, 64'h1100, 16'hABCD);
    step();
    checks++; if ({bus.o_dram_data_o_valid, bus.o_dram_data_o} !== 17'h1_ABCD) begin
      failures++; $display("FAIL wb_data actual=%h expected=1abcd", {bus.o_dram_data_o_valid, bus.o_dram_data_o}); end
    checks++; if (bus.o_dram_addr !== 64'h100) begin failures++; $display("FAIL wb_addr actual=%h expected=100", bus.o_dram_addr); end
    step();
    checks++; if ({bus.o_dram_data_o_valid, bus.o_dram_data_o, bus.o_dram_addr} !== {1'b1, 16'hABCD, 64'h100}) begin
      failures++; $display("FAIL wb_hold actual=%h expected=1abcd0000000000000100", {bus.o_dram_data_o_valid, bus.o_dram_data_o, bus.o_dram_addr}); end
    bus.i_dram_data_o_ready = 1'b1;
    step();
    bus.i_dram_data_o_ready = 1'b0;
    checks++; if ({bus.o_dram_data_o_valid, bus.o_type_ready, bus.o_dram_data_i_ready} !== 3'b010) begin
      failures++; $display("FAIL wb_done actual=%b expected=010", {bus.o_dram_data_o_valid, bus.o_type_ready, bus.o_dram_data_i_ready}); end
    issue(READ, 64'h1100, 16'h0);
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready} !== {1'b1, 16'hABCD, 1'b0}) begin
      failures++; $display("FAIL rd17_hit actual=%h expected=3579a", {bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready}); end
    pe_take();
  endtask

  task automatic test_consume();
    issue(CONSUME, 64'h0000_0000_FFFF_FFFF, 16'h0);
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready} !== 18'h2_0000) begin
      failures++; $display("FAIL cons_resp actual=%h expected=20000", {bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready}); end
    pe_take();
    issue(READ, 64'h0000_0000_FFFF_FFFF, 16'h0);
    step();
    checks++; if ({bus.o_dram_data_i_ready, bus.o_pe_data_o_valid, bus.o_dram_addr} !== {2'b10, 64'h0000_0000_FFFF_FFFF}) begin
      failures++; $display("FAIL cons_inval actual=%h expected=200000000ffffffff", {bus.o_dram_data_i_ready, bus.o_pe_data_o_valid, bus.o_dram_addr}); end
    fill(16'h2468);
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o} !== 17'h1_2468) begin
      failures++; $display("FAIL refill_resp actual=%h expected=12468", {bus.o_pe_data_o_valid, bus.o_pe_data_o}); end
    pe_take();
    issue(FETCH, 64'h5A5A, 16'h0);
    step();
    fill(16'h1234);
    issue(FETCH, 64'h5A5A, 16'h0);
    step();
    checks++; if ({bus.o_type_ready, bus.o_dram_data_i_ready} !== 2'b10) begin
      failures++; $display("FAIL fetch_hit actual=%b expected=10", {bus.o_type_ready, bus.o_dram_data_i_ready}); end
    issue(CONSUME, 64'h5A5A, 16'h0);
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o} !== 17'h1_1234) begin
      failures++; $display("FAIL cons_p2_resp actual=%h expected=11234", {bus.o_pe_data_o_valid, bus.o_pe_data_o}); end
    pe_take();
    issue(READ, 64'h5A5A, 16'h0);
    step();
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready} !== {1'b1, 16'h1234, 1'b0}) begin
      failures++; $display("FAIL cons_p2_kept actual=%h expected=22468", {bus.o_pe_data_o_valid, bus.o_pe_data_o, bus.o_dram_data_i_ready}); end
    pe_take();
    issue(CONSUME, 64'h7777, 16'h0);
    step();
    checks++; if ({bus.o_dram_data_i_ready, bus.o_dram_addr} !== {1'b1, 64'h7777}) begin
      failures++; $display("FAIL cons_miss_fill actual=%h expected=10000000000007777", {bus.o_dram_data_i_ready, bus.o_dram_addr}); end
    fill(16'h0BAD);
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o} !== 17'h1_0BAD) begin
      failures++; $display("FAIL cons_miss_resp actual=%h expected=10bad", {bus.o_pe_data_o_valid, bus.o_pe_data_o}); end
    pe_take();
    issue(READ, 64'h7777, 16'h0);
    step();
    checks++; if ({bus.o_dram_data_i_ready, bus.o_pe_data_o_valid} !== 2'b10) begin
      failures++; $display("FAIL cons_no_alloc actual=%b expected=10", {bus.o_dram_data_i_ready, bus.o_pe_data_o_valid}); end
    fill(16'h0001);
    pe_take();
  endtask

  task automatic test_bad_type();
    issue(4'b0011, 64'h5A5A, 16'h0);
    checks++; if (bus.o_type_ready !== 1'b0) begin failures++; $display("FAIL bad_busy actual=%b expected=0", bus.o_type_ready); end
    step();
    checks++; if ({bus.o_type_ready, bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid} !== 4'b1000) begin
      failures++; $display("FAIL bad_drop actual=%b expected=1000", {bus.o_type_ready, bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid}); end
    fill(16'hDEAD);
    checks++; if ({bus.o_type_ready, bus.o_pe_data_o_valid} !== 2'b10) begin
      failures++; $display("FAIL stray_fill actual=%b expected=10", {bus.o_type_ready, bus.o_pe_data_o_valid}); end
  endtask

  task automatic test_reset_fill();
    issue(READ, 64'h3333, 16'h0);
    step();
    checks++; if (bus.o_dram_data_i_ready !== 1'b1) begin failures++; $display("FAIL rf_fill actual=%b expected=1", bus.o_dram_data_i_ready); end
    i_nreset = 1'b0;
    #1;
    checks++; if ({bus.o_type_ready, bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid} !== 4'b1000) begin
      failures++; $display("FAIL rf_rst_flags actual=%b expected=1000", {bus.o_type_ready, bus.o_pe_data_o_valid, bus.o_dram_data_i_ready, bus.o_dram_data_o_valid}); end
    checks++; if ({bus.o_pe_data_o, bus.o_dram_data_o, bus.o_dram_addr} !== 96'h0) begin
      failures++; $display("FAIL rf_rst_data actual=%h expected=0", {bus.o_pe_data_o, bus.o_dram_data_o, bus.o_dram_addr}); end
    @(negedge i_clk);
    i_nreset = 1'b1;
    @(negedge i_clk);
    issue(READ, 64'h3333, 16'h0);
    step();
    checks++; if ({bus.o_dram_data_i_ready, bus.o_dram_addr} !== {1'b1, 64'h3333}) begin
      failures++; $display("FAIL rf_remiss actual=%h expected=10000000000003333", {bus.o_dram_data_i_ready, bus.o_dram_addr}); end
    fill(16'h3C3C);
    checks++; if ({bus.o_pe_data_o_valid, bus.o_pe_data_o} !== 17'h1_3C3C) begin
      failures++; $display("FAIL rf_resp actual=%h expected=13c3c", {bus.o_pe_data_o_valid, bus.o_pe_data_o}); end
    pe_take();
  endtask

  initial begin
    bus.i_request_type      = '0;
    bus.i_addr              = '0;
    bus.i_type_valid        = 1'b0;
    bus.i_data              = '0;
    bus.i_pe_data_o_ready   = 1'b0;
    bus.i_dram_data         = '0;
    bus.i_dram_data_i_valid = 1'b0;
    bus.i_dram_data_o_ready = 1'b0;
    test_reset();
    test_fetch_miss();
    test_read_hold();
    test_write_evict();
    test_consume();
    test_bad_type();
    test_reset_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
